// File: rtl/dcacheread_fetch_if.sv
// Request-side and memory-bus signals of the dcache read fetch unit.
// The fetch unit is the bus master; the slave modport is its environment.
interface dcacheread_fetch_if;
    logic        dcacheread_do;
    logic        dcacheread_done;
    logic [3:0]  dcacheread_length;
    logic        dcacheread_cache_disable;
    logic [31:0] dcacheread_address;
    logic [63:0] dcacheread_data;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_uncached;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;

    modport master (
        input  dcacheread_do, dcacheread_length, dcacheread_cache_disable, dcacheread_address,
        input  mem_waitrequest, mem_readdatavalid, mem_readdata,
        output dcacheread_done, dcacheread_data, mem_address, mem_read, mem_uncached
    );

    modport slave (
        output dcacheread_do, dcacheread_length, dcacheread_cache_disable, dcacheread_address,
        output mem_waitrequest, mem_readdatavalid, mem_readdata,
        input  dcacheread_done, dcacheread_data, mem_address, mem_read, mem_uncached
    );
endinterface

// File: rtl/dcacheread_fetch.sv
// Fetches an arbitrarily aligned 0..8 byte read as 1..3 dword bus reads, one outstanding,
// and presents the assembled little-endian data with a one-cycle done pulse.
module dcacheread_fetch (
    input logic                 clk,
    input logic                 rst_n,
    dcacheread_fetch_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic        uncached_q, uncached_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  idx_q, idx_d;
    logic [95:0] buf_q, buf_d;
    logic [63:0] data_q, data_d;
    logic [4:0]  span;

    // Align the fetched line to the request and zero every byte past the requested length.
    function automatic logic [63:0] assemble(logic [95:0] line, logic [1:0] off, logic [3:0] len);
        logic [95:0] sh;
        logic [63:0] res;
        sh = line >> {off, 3'b000};
        for (int i = 0; i < 8; i++) begin
            res[8*i +: 8] = (4'(i) < len) ? sh[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        uncached_d = uncached_q;
        last_d     = last_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        data_d     = data_q;
        span       = {3'b000, bus.dcacheread_address[1:0]} + {1'b0, bus.dcacheread_length}
                     - 5'd1;

        unique case (state_q)
            StIdle: begin
                if (bus.dcacheread_do) begin
                    addr_d     = bus.dcacheread_address;
                    len_d      = bus.dcacheread_length;
                    uncached_d = bus.dcacheread_cache_disable;
                    last_d     = 2'(span >> 2);
                    idx_d      = 2'd0;
                    if (bus.dcacheread_length == 4'd0 || bus.dcacheread_length > 4'd8) begin
                        data_d  = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!bus.mem_waitrequest) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.mem_readdatavalid) begin
                    buf_d[{idx_q, 5'd0} +: 32] = bus.mem_readdata;
                    if (idx_q == last_q) begin
                        data_d  = assemble(buf_d, addr_q[1:0], len_q);
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            uncached_q <= 1'b0;
            last_q     <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            uncached_q <= uncached_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            data_q     <= data_d;
        end
    end

    // Address wraps naturally in 30 bits; held steady through a stall since idx only moves in WAIT.
    assign bus.mem_address     = addr_q[31:2] + 30'(idx_q);
    assign bus.mem_read        = (state_q == StIssue);
    assign bus.mem_uncached    = (state_q != StIdle) && uncached_q;
    assign bus.dcacheread_done = (state_q == StDone);
    assign bus.dcacheread_data = data_q;

endmodule

// File: tb/tb_dcacheread_fetch.sv
// Directed bench for dcacheread_fetch: a small bus responder lives in the tick task,
// expected values are hand-computed constants.
module tb_dcacheread_fetch;

    logic clk;
    logic rst_n;

    dcacheread_fetch_if bif ();

    dcacheread_fetch u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] words [3];
    int          rd_idx;
    logic [29:0] addr_log [$];
    logic        uncached_seen;
    logic        resp_hold;
    int          stall_left;
    int          stall_cnt;
    logic        stall_stable;
    logic [29:0] stall_addr;
    int          done_cnt;
    int          lat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample the bus before the edge, then drive the response after it.
    task automatic tick();
        logic        accepted;
        logic [29:0] a;
        accepted = bif.mem_read && !bif.mem_waitrequest;
        a        = bif.mem_address;
        if (bif.mem_read) uncached_seen = uncached_seen | bif.mem_uncached;
        if (bif.mem_read && bif.mem_waitrequest) begin
            if (stall_cnt > 0 && bif.mem_address != stall_addr) stall_stable = 1'b0;
            stall_addr = bif.mem_address;
            stall_cnt++;
            stall_left--;
        end
        @(posedge clk);
        #1;
        bif.mem_readdatavalid = 1'b0;
        if (accepted) begin
            addr_log.push_back(a);
            if (!resp_hold) begin
                bif.mem_readdatavalid = 1'b1;
                bif.mem_readdata      = words[rd_idx];
                rd_idx++;
            end
        end
        bif.mem_waitrequest = (stall_left > 0);
        if (bif.dcacheread_done) done_cnt++;
    endtask

    task automatic run_req(input logic [31:0] a, input logic [3:0] l, input logic cd,
                           output int latency);
        bif.dcacheread_address       = a;
        bif.dcacheread_length        = l;
        bif.dcacheread_cache_disable = cd;
        bif.dcacheread_do            = 1'b1;
        rd_idx        = 0;
        uncached_seen = 1'b0;
        addr_log.delete();
        latency = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bif.dcacheread_done) begin
                latency = c;
                break;
            end
        end
        bif.dcacheread_do = 1'b0;
    endtask

    initial begin
        rst_n                        = 1'b0;
        bif.dcacheread_do            = 1'b0;
        bif.dcacheread_length        = '0;
        bif.dcacheread_cache_disable = 1'b0;
        bif.dcacheread_address       = '0;
        bif.mem_waitrequest          = 1'b0;
        bif.mem_readdatavalid        = 1'b0;
        bif.mem_readdata             = '0;
        resp_hold    = 1'b0;
        stall_left   = 0;
        stall_cnt    = 0;
        stall_stable = 1'b1;
        stall_addr   = '0;
        done_cnt     = 0;
        rd_idx       = 0;
        words[0] = '0; words[1] = '0; words[2] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_done", 64'(bif.dcacheread_done), 64'd0);
        check_eq("rst_data", bif.dcacheread_data, 64'd0);
        check_eq("rst_mem_read", 64'(bif.mem_read), 64'd0);
        check_eq("rst_mem_address", 64'(bif.mem_address), 64'd0);
        check_eq("rst_uncached", 64'(bif.mem_uncached), 64'd0);
        tick();

        // Aligned single dword, uncached
        words[0] = 32'hDDCCBBAA;
        run_req(32'h0000_1000, 4'd4, 1'b1, lat);
        check_eq("aligned_latency", 64'(lat), 64'd3);
        check_eq("aligned_data", bif.dcacheread_data, 64'h0000_0000_DDCC_BBAA);
        check_eq("aligned_nreads", 64'(addr_log.size()), 64'd1);
        if (addr_log.size() > 0) check_eq("aligned_addr", 64'(addr_log[0]), 64'h400);
        check_eq("aligned_uncached", 64'(uncached_seen), 64'd1);
        tick();
        check_eq("idle_uncached", 64'(bif.mem_uncached), 64'd0);
        check_eq("idle_mem_read", 64'(bif.mem_read), 64'd0);

        // Unaligned three-dword read
        words[0] = 32'h33221100; words[1] = 32'h77665544; words[2] = 32'hBBAA9988;
        run_req(32'h0000_1003, 4'd8, 1'b0, lat);
        check_eq("unal_data", bif.dcacheread_data, 64'hAA99_8877_6655_4433);
        check_eq("unal_nreads", 64'(addr_log.size()), 64'd3);
        if (addr_log.size() == 3) begin
            check_eq("unal_addr0", 64'(addr_log[0]), 64'h400);
            check_eq("unal_addr1", 64'(addr_log[1]), 64'h401);
            check_eq("unal_addr2", 64'(addr_log[2]), 64'h402);
        end
        check_eq("unal_uncached", 64'(uncached_seen), 64'd0);
        tick();
        tick();
        check_eq("unal_data_held", bif.dcacheread_data, 64'hAA99_8877_6655_4433);
        check_eq("unal_no_extra_read", 64'(addr_log.size()), 64'd3);

        // Address wrap across the top of the dword space
        words[0] = 32'h44332211; words[1] = 32'h88776655;
        run_req(32'hFFFF_FFFE, 4'd4, 1'b0, lat);
        check_eq("wrap_data", bif.dcacheread_data, 64'h0000_0000_6655_4433);
        check_eq("wrap_nreads", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) begin
            check_eq("wrap_addr0", 64'(addr_log[0]), 64'h3FFF_FFFF);
            check_eq("wrap_addr1", 64'(addr_log[1]), 64'h0);
        end
        tick();

        // Partial length masks trailing bytes
        words[0] = 32'hDDCCBBAA;
        run_req(32'h0000_1001, 4'd3, 1'b0, lat);
        check_eq("mask_data", bif.dcacheread_data, 64'h0000_0000_00DD_CCBB);
        tick();

        // Five-cycle stall on the first read
        words[0] = 32'h12345678;
        stall_left = 5; stall_cnt = 0; stall_stable = 1'b1;
        bif.mem_waitrequest = 1'b1;
        run_req(32'h0000_1004, 4'd2, 1'b0, lat);
        check_eq("stall_cycles", 64'(stall_cnt), 64'd5);
        check_eq("stall_addr_stable", 64'(stall_stable), 64'd1);
        check_eq("stall_nreads", 64'(addr_log.size()), 64'd1);
        if (addr_log.size() > 0) check_eq("stall_addr", 64'(addr_log[0]), 64'h401);
        check_eq("stall_latency", 64'(lat), 64'd8);
        check_eq("stall_data", bif.dcacheread_data, 64'h0000_0000_0000_5678);
        tick();

        // Length 0 and length 9: no bus traffic, zero data
        run_req(32'h0000_0020, 4'd0, 1'b0, lat);
        check_eq("len0_latency", 64'(lat), 64'd1);
        check_eq("len0_nreads", 64'(addr_log.size()), 64'd0);
        check_eq("len0_data", bif.dcacheread_data, 64'd0);
        tick();
        words[0] = 32'hCAFEF00D;
        run_req(32'h0000_1000, 4'd4, 1'b0, lat);
        tick();
        run_req(32'h0000_0000, 4'd9, 1'b0, lat);
        check_eq("len9_latency", 64'(lat), 64'd1);
        check_eq("len9_nreads", 64'(addr_log.size()), 64'd0);
        check_eq("len9_data", bif.dcacheread_data, 64'd0);
        tick();

        // Stray readdatavalid in IDLE must not disturb data or raise done
        done_cnt = 0;
        bif.mem_readdatavalid = 1'b1;
        bif.mem_readdata      = 32'hFFFF_FFFF;
        tick();
        tick();
        check_eq("stray_done", 64'(done_cnt), 64'd0);
        check_eq("stray_data", bif.dcacheread_data, 64'd0);

        // Reset while waiting for read data, then a stale response
        words[0] = 32'h0BAD_0BAD;
        resp_hold = 1'b1;
        addr_log.delete();
        bif.dcacheread_address       = 32'h0000_1000;
        bif.dcacheread_length        = 4'd4;
        bif.dcacheread_cache_disable = 1'b1;
        bif.dcacheread_do            = 1'b1;
        tick();
        tick();
        bif.dcacheread_do = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        done_cnt = 0;
        bif.mem_readdatavalid = 1'b1;
        bif.mem_readdata      = 32'h0BAD_0BAD;
        tick();
        tick();
        tick();
        check_eq("rstwait_nreads", 64'(addr_log.size()), 64'd1);
        check_eq("rstwait_done", 64'(done_cnt), 64'd0);
        check_eq("rstwait_data", bif.dcacheread_data, 64'd0);
        check_eq("rstwait_mem_read", 64'(bif.mem_read), 64'd0);
        check_eq("rstwait_mem_address", 64'(bif.mem_address), 64'd0);
        check_eq("rstwait_uncached", 64'(bif.mem_uncached), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
